// File: rtl/iob_plic_dispatcher.sv
// Hardware claim/complete sequencer for one IOb PLIC target: claims the pending ID,
// hands it to a hardware handler, then writes the completion back after done or timeout.
module iob_plic_dispatcher #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 32,
  parameter int                SOURCES_BITS   = 7,
  parameter logic [ADDR_W-1:0] CLAIM_ADDR     = 'h0100,
  parameter int                TIMEOUT        = 1024,
  parameter int                HOLDOFF_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    irq,
  output logic                    m_valid,
  output logic [ADDR_W-1:0]       m_address,
  output logic [DATA_W-1:0]       m_wdata,
  output logic [DATA_W/8-1:0]     m_wstrb,
  input  logic [DATA_W-1:0]       m_rdata,
  input  logic                    m_ready,
  output logic                    id_valid,
  output logic [SOURCES_BITS-1:0] id,
  input  logic                    id_ready,
  input  logic                    done,
  output logic                    busy,
  output logic                    spurious,
  output logic                    timeout
);

  localparam int CNT_MAX = (TIMEOUT > HOLDOFF_CYCLES) ? TIMEOUT : HOLDOFF_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM_RD,
    S_DISPATCH,
    S_WAIT_DONE,
    S_COMPLETE_WR,
    S_HOLDOFF
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SOURCES_BITS-1:0] id_q, id_d;
  logic                    spurious_q, spurious_d;
  logic                    expired;
  logic                    unused_rdata;

  // Only the ID field of the claim read is meaningful.
  assign unused_rdata = ^m_rdata;

  assign expired = (TIMEOUT != 0) && (state_q == S_WAIT_DONE) &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    spurious_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en && irq) state_d = S_CLAIM_RD;
      end
      S_CLAIM_RD: begin
        if (m_ready) begin
          id_d = m_rdata[SOURCES_BITS-1:0];
          if (m_rdata[SOURCES_BITS-1:0] == '0) begin
            spurious_d = 1'b1;
            cnt_d      = '0;
            state_d    = S_HOLDOFF;
          end else begin
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (id_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A simultaneous done takes precedence; the timeout pulse is masked by done.
        if (done || expired) state_d = S_COMPLETE_WR;
      end
      S_COMPLETE_WR: begin
        if (m_ready) begin
          cnt_d   = '0;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) state_d = S_IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      id_q       <= '0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      spurious_q <= spurious_d;
    end
  end

  assign m_valid   = (state_q == S_CLAIM_RD) || (state_q == S_COMPLETE_WR);
  assign m_address = m_valid ? CLAIM_ADDR : '0;
  assign m_wstrb   = (state_q == S_COMPLETE_WR) ? '1 : '0;
  assign m_wdata   = (state_q == S_COMPLETE_WR) ? DATA_W'(id_q) : '0;
  assign id_valid  = (state_q == S_DISPATCH);
  assign id        = id_q;
  assign busy      = (state_q != S_IDLE);
  assign spurious  = spurious_q;
  assign timeout   = expired && !done;

endmodule

// File: tb/tb_iob_plic_dispatcher.sv
// Directed bench for iob_plic_dispatcher: PLIC model answers one cycle after m_valid,
// bus transactions and ID handoffs are checked against scoreboard queues.
module tb_iob_plic_dispatcher;
  localparam int          TMO   = 8;
  localparam logic [15:0] CADDR = 16'h0100;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, irq = 1'b0;
  logic        m_ready = 1'b0, id_ready = 1'b0, done = 1'b0;
  logic        m_valid, id_valid, busy, spurious, timeout;
  logic [15:0] m_address;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic [3:0]  m_wstrb;
  logic [6:0]  id;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } bus_t;

  bus_t       exp_bus[$];
  logic [6:0] exp_id[$];
  bus_t       e_bus;
  logic [6:0] e_id;
  int checks = 0, errors = 0, spur_cnt = 0, tmo_cnt = 0;

  iob_plic_dispatcher #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .irq(irq),
    .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .id_valid(id_valid), .id(id), .id_ready(id_ready), .done(done),
    .busy(busy), .spurious(spurious), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // PLIC model: responds one cycle after m_valid, which also yields a trailing ready.
  always @(posedge clk) m_ready <= m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_claim(input logic [6:0] v);
    m_rdata = {25'h1A5A5A5, v};
  endtask

  task automatic push_read();
    exp_bus.push_back('{1'b0, CADDR, 32'h0, 4'h0});
  endtask

  task automatic push_write(input logic [6:0] v);
    exp_bus.push_back('{1'b1, CADDR, 32'(v), 4'hF});
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {m_valid, m_address, m_wstrb, id_valid, id, busy, spurious, timeout}, 32'h0);
    chk(tag, m_wdata, 32'h0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 40) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(busy), 32'h0);
  endtask

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      if (exp_bus.size() == 0) chk("bus_unexpected", 32'(exp_bus.size()), 32'h1);
      else begin
        e_bus = exp_bus.pop_front();
        $display("bus %s addr=%h data=%h strb=%h", m_wstrb != 0 ? "WR" : "RD", m_address, m_wdata, m_wstrb);
        chk("bus_dir", 32'(m_wstrb != 4'h0), 32'(e_bus.wr));
        chk("bus_addr", 32'(m_address), 32'(e_bus.addr));
        chk("bus_data", m_wdata, e_bus.data);
        chk("bus_strb", 32'(m_wstrb), 32'(e_bus.strb));
      end
    end
    if (id_valid && id_ready) begin
      if (exp_id.size() == 0) chk("id_unexpected", 32'(exp_id.size()), 32'h1);
      else begin
        e_id = exp_id.pop_front();
        $display("dispatch id=%0d", id);
        chk("id_handoff", 32'(id), 32'(e_id));
      end
    end
    if (spurious) spur_cnt++;
    if (timeout) tmo_cnt++;
  end

  initial begin
    tick(2);
    chk_zero("reset");
    rst_n = 1'b1;

    // Normal sequence: ID 5, immediate id_ready, done three cycles into WAIT_DONE.
    set_claim(7'd5); push_read(); exp_id.push_back(7'd5); push_write(7'd5);
    en = 1'b1; irq = 1'b1; id_ready = 1'b1;
    tick(1);
    chk("claim_valid", 32'(m_valid), 32'h1);
    chk("claim_addr", 32'(m_address), 32'(CADDR));
    chk("claim_strb", 32'(m_wstrb), 32'h0);
    chk("busy_claim", 32'(busy), 32'h1);
    tick(1);
    chk("idv_c2", 32'(id_valid), 32'h0);
    tick(1); irq = 1'b0;
    chk("idv_c3", 32'(id_valid), 32'h1);
    chk("id_c3", 32'(id), 32'd5);
    chk("mvalid_gap", 32'(m_valid), 32'h0);
    tick(1);
    chk("wait_idv", 32'(id_valid), 32'h0);
    tick(2); done = 1'b1;
    tick(1); done = 1'b0;
    chk("wr_valid", 32'(m_valid), 32'h1);
    chk("wr_strb", 32'(m_wstrb), 32'hF);
    chk("wr_data", m_wdata, 32'd5);
    tick(2);
    chk("hold1_busy", 32'(busy), 32'h1);
    chk("trail_ignored", 32'(m_valid), 32'h0);
    tick(1);
    chk("hold2_busy", 32'(busy), 32'h1);
    tick(1);
    chk("idle_busy", 32'(busy), 32'h0);

    // Spurious claim: ID field reads 0 despite nonzero upper bits.
    set_claim(7'd0); push_read(); spur_cnt = 0; irq = 1'b1;
    tick(1); irq = 1'b0;
    tick(2);
    chk("spur_pulse", 32'(spurious), 32'h1);
    chk("spur_idv", 32'(id_valid), 32'h0);
    chk("spur_id", 32'(id), 32'h0);
    tick(1);
    chk("spur_low", 32'(spurious), 32'h0);
    chk("spur_hold", 32'(busy), 32'h1);
    tick(1);
    chk("spur_idle", 32'(busy), 32'h0);
    chk("spur_cnt", 32'(spur_cnt), 32'h1);

    // Timeout: done never arrives.
    set_claim(7'd9); push_read(); exp_id.push_back(7'd9); push_write(7'd9);
    tmo_cnt = 0; irq = 1'b1;
    tick(1); irq = 1'b0;
    tick(9);
    chk("to_early", 32'(timeout), 32'h0);
    tick(1);
    chk("to_pulse", 32'(timeout), 32'h1);
    chk("to_novalid", 32'(m_valid), 32'h0);
    tick(1);
    chk("to_low", 32'(timeout), 32'h0);
    chk("to_wr_valid", 32'(m_valid), 32'h1);
    chk("to_wr_data", m_wdata, 32'd9);
    wait_idle("to_idle");
    chk("to_cnt", 32'(tmo_cnt), 32'h1);

    // Backpressure on id_ready, done pulse in DISPATCH ignored, done/expiry collision.
    set_claim(7'd42); push_read(); exp_id.push_back(7'd42); push_write(7'd42);
    tmo_cnt = 0; id_ready = 1'b0; irq = 1'b1;
    tick(1); irq = 1'b0;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(id_valid), 32'h1);
      chk("bp_id", 32'(id), 32'd42);
      done = (i == 4);
      tick(1);
    end
    id_ready = 1'b1;
    tick(1);
    chk("bp_released", 32'(id_valid), 32'h0);
    tick(6);
    chk("col_early", 32'(timeout), 32'h0);
    tick(1); done = 1'b1; #1;
    chk("col_no_to", 32'(timeout), 32'h0);
    tick(1); done = 1'b0;
    chk("col_wr_valid", 32'(m_valid), 32'h1);
    chk("col_wr_data", m_wdata, 32'd42);
    wait_idle("col_idle");
    chk("col_to_cnt", 32'(tmo_cnt), 32'h0);

    // Enable dropped during WAIT_DONE: completion still written, then no new claim.
    set_claim(7'd3); push_read(); exp_id.push_back(7'd3); push_write(7'd3);
    irq = 1'b1;
    tick(4); en = 1'b0;
    tick(1); done = 1'b1;
    tick(1); done = 1'b0;
    chk("en_wr_valid", 32'(m_valid), 32'h1);
    chk("en_wr_data", m_wdata, 32'd3);
    wait_idle("en_idle");
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("en_off_quiet", {31'h0, m_valid | busy}, 32'h0);
    end

    // Re-enable, then reset during CLAIM_RD.
    set_claim(7'd7); en = 1'b1;
    tick(1);
    chk("reen_claim", 32'(m_valid), 32'h1);
    rst_n = 1'b0;
    tick(1);
    chk_zero("rst_claim");
    push_read(); exp_id.push_back(7'd7);
    rst_n = 1'b1;
    tick(1);
    chk("rst_fresh", 32'(m_valid), 32'h1);
    tick(2); irq = 1'b0;
    tick(1); done = 1'b1;
    tick(1); done = 1'b0;
    chk("pre_rst_wr", 32'(m_wstrb), 32'hF);
    rst_n = 1'b0;
    tick(1);
    chk_zero("rst_write");

    // Release with irq high: a fresh full sequence (completed by timeout).
    set_claim(7'd11); push_read(); exp_id.push_back(7'd11); push_write(7'd11);
    rst_n = 1'b1; irq = 1'b1;
    tick(1);
    chk("final_claim", 32'(m_valid), 32'h1);
    irq = 1'b0;
    wait_idle("final_idle");

    chk("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
    chk("id_queue_empty", 32'(exp_id.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
